// File: rtl/if_id_queue_pkg.sv
// ---------------------------------------------------------------------------
// if_id_queue_pkg
// Shared definitions for the IF/ID instruction queue slice:
//   - reset/stall encodings and bus widths used by the OpenMIPS pipeline
//   - default queue depth
//   - queue operation encoding plus a helper that derives it from push/pop
// ---------------------------------------------------------------------------
package if_id_queue_pkg;

   localparam logic        RST_ENABLE     = 1'b1;
   localparam logic        STOP           = 1'b1;
   localparam logic        NO_STOP        = 1'b0;
   localparam logic [31:0] ZERO_WORD      = 32'h0000_0000;
   localparam int          INST_ADDR_W    = 32;
   localparam int          INST_BUS_W     = 32;
   localparam int          IF_QUEUE_DEPTH = 4;

   // Encoding is {pop, push} so the helper is a plain cast.
   typedef enum logic [1:0] {
      Q_IDLE = 2'b00,
      Q_PUSH = 2'b01,
      Q_POP  = 2'b10,
      Q_BOTH = 2'b11
   } q_op_t;

   function automatic q_op_t q_op(input logic push, input logic pop);
      return q_op_t'({pop, push});
   endfunction

endpackage

// File: rtl/if_id_queue_if.sv
// ---------------------------------------------------------------------------
// if_id_queue_if
// Bundles the IF-side offer, the ID-side presentation and the flush/stall
// controls of the IF/ID queue.
//   master : pipeline side (drives flush, if_valid/if_pc/if_inst, id_stall)
//   slave  : queue side    (drives if_ready, id_valid/id_pc/id_inst, count)
// ---------------------------------------------------------------------------
interface if_id_queue_if #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32,
   parameter int DEPTH  = 4
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic              flush;
   logic              if_valid;
   logic [ADDR_W-1:0] if_pc;
   logic [INST_W-1:0] if_inst;
   logic              if_ready;
   logic              id_stall;
   logic              id_valid;
   logic [ADDR_W-1:0] id_pc;
   logic [INST_W-1:0] id_inst;
   logic [CNT_W-1:0]  count;

   modport master (
      output flush, if_valid, if_pc, if_inst, id_stall,
      input  if_ready, id_valid, id_pc, id_inst, count
   );

   modport slave (
      input  flush, if_valid, if_pc, if_inst, id_stall,
      output if_ready, id_valid, id_pc, id_inst, count
   );

endinterface

// File: rtl/if_id_queue_mem.sv
// ---------------------------------------------------------------------------
// if_id_queue_mem
// DEPTH x (ADDR_W+INST_W) entry store with write/read pointers. Data has no
// reset; only the pointers are cleared.
//   clk, rst      : clock, synchronous active-high reset of the pointers
//   clr           : pointer clear (flush)
//   push, wr_pc,
//   wr_inst       : write one entry at the write pointer
//   pop           : advance the read pointer (presented entry consumed)
//   nxt_pc,
//   nxt_inst      : entry one past the read pointer, i.e. the entry that
//                   becomes presented after a pop
// ---------------------------------------------------------------------------
module if_id_queue_mem #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              push,
   input  logic [ADDR_W-1:0] wr_pc,
   input  logic [INST_W-1:0] wr_inst,
   input  logic              pop,
   output logic [ADDR_W-1:0] nxt_pc,
   output logic [INST_W-1:0] nxt_inst
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int ENT_W = ADDR_W + INST_W;

   logic [ENT_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_plus;

   // DEPTH is a power of two, so pointer overflow is the modulo wrap.
   assign rd_ptr_plus = rd_ptr_reg + PTR_W'(1);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_plus;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_reg] <= {wr_pc, wr_inst};
   end

   assign {nxt_pc, nxt_inst} = mem[rd_ptr_plus];

endmodule

// File: rtl/if_id_queue.sv
// ---------------------------------------------------------------------------
// if_id_queue
// DEPTH-entry IF/ID instruction queue. The oldest entry is held in output
// registers and presented to ID; the entry store also keeps it so that the
// read pointer always marks the presented slot. An empty queue presents the
// zero bubble (PC 0, inst 0).
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : if_id_queue_if.slave -- IF offer/ready, ID valid/pc/inst,
//          id_stall, flush, occupancy count
// ---------------------------------------------------------------------------
module if_id_queue
   import if_id_queue_pkg::*;
#(
   parameter int ADDR_W = INST_ADDR_W,
   parameter int INST_W = INST_BUS_W,
   parameter int DEPTH  = IF_QUEUE_DEPTH
) (
   input  logic          clk,
   input  logic          rst,
   if_id_queue_if.slave  bus
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [CNT_W-1:0]  count_reg,    count_next;
   logic              id_valid_reg, id_valid_next;
   logic [ADDR_W-1:0] id_pc_reg,    id_pc_next;
   logic [INST_W-1:0] id_inst_reg,  id_inst_next;

   logic              if_ready;
   logic              push;
   logic              pop;
   logic              clr;
   q_op_t             op;
   logic [ADDR_W-1:0] nxt_pc;
   logic [INST_W-1:0] nxt_inst;

   // Ready depends on the registered count only: a full queue never accepts,
   // even when ID is consuming in the same cycle.
   assign if_ready = (count_reg < CNT_FULL);
   assign push     = bus.if_valid && if_ready && !bus.flush;
   assign pop      = id_valid_reg && (bus.id_stall == NO_STOP);
   assign clr      = (rst == RST_ENABLE) || bus.flush;
   assign op       = q_op(push, pop);

   if_id_queue_mem #(
      .ADDR_W (ADDR_W),
      .INST_W (INST_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk      (clk),
      .rst      (rst),
      .clr      (bus.flush),
      .push     (push),
      .wr_pc    (bus.if_pc),
      .wr_inst  (bus.if_inst),
      .pop      (pop),
      .nxt_pc   (nxt_pc),
      .nxt_inst (nxt_inst)
   );

   always_comb begin
      count_next    = count_reg;
      id_valid_next = id_valid_reg;
      id_pc_next    = id_pc_reg;
      id_inst_next  = id_inst_reg;
      if (clr) begin
         count_next    = '0;
         id_valid_next = 1'b0;
         id_pc_next    = '0;
         id_inst_next  = '0;
      end else begin
         unique case (op)
            Q_PUSH: begin
               count_next = count_reg + CNT_ONE;
               // Empty queue: the new entry is presented straight away.
               if (count_reg == '0) begin
                  id_valid_next = 1'b1;
                  id_pc_next    = bus.if_pc;
                  id_inst_next  = bus.if_inst;
               end
            end
            Q_POP: begin
               count_next = count_reg - CNT_ONE;
               if (count_reg == CNT_ONE) begin
                  id_valid_next = 1'b0;
                  id_pc_next    = '0;
                  id_inst_next  = '0;
               end else begin
                  id_pc_next    = nxt_pc;
                  id_inst_next  = nxt_inst;
               end
            end
            Q_BOTH: begin
               // With a single entry the slot after it is the one being
               // written this cycle, so take the offer directly.
               if (count_reg == CNT_ONE) begin
                  id_pc_next   = bus.if_pc;
                  id_inst_next = bus.if_inst;
               end else begin
                  id_pc_next   = nxt_pc;
                  id_inst_next = nxt_inst;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      count_reg    <= count_next;
      id_valid_reg <= id_valid_next;
      id_pc_reg    <= id_pc_next;
      id_inst_reg  <= id_inst_next;
   end

   assign bus.if_ready = if_ready;
   assign bus.id_valid = id_valid_reg;
   assign bus.id_pc    = id_pc_reg;
   assign bus.id_inst  = id_inst_reg;
   assign bus.count    = count_reg;

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
Parametrised IF/ID boundary for the OpenMIPS pipeline.
- Replaces the single-entry IF/ID register with a DEPTH-entry instruction queue.
- Fetch can keep running while decode is stalled.
- Branch/exception flush empties the queue.
- Empty-queue and flushed slots present the zero-word bubble (PC 0, inst 0 = NOP) to ID, as the existing pipeline registers do.

Parameters:
ADDR_W, 32, width of instruction address (PC).
INST_W, 32, width of instruction word.
DEPTH, 4, queue capacity in entries including the entry presented to ID; power of 2, >= 2.
CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  reset, synchronous, active-high.
flush  input  1  discard all queued and presented entries (branch taken / exception).
if_valid  input  1  IF offers if_pc/if_inst this cycle.
if_pc  input  ADDR_W  PC of offered instruction.
if_inst  input  INST_W  offered instruction word.
if_ready  output  1  queue accepts an entry this cycle.
id_stall  input  1  ID cannot consume this cycle (pause[2] equivalent).
id_valid  output  1  id_pc/id_inst hold a real instruction.
id_pc  output  ADDR_W  PC presented to ID.
id_inst  output  INST_W  instruction presented to ID.
count  output  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst=1 at posedge, including mid-operation):
  - count=0, id_valid=0, id_pc=0, id_inst=0.
  - Internal read/write pointers = 0.
  - Push/pop in the same cycle are ignored.
- Handshakes:
  - push = if_valid && if_ready && !flush.
  - pop = id_valid && !id_stall.
- if_ready = (count < DEPTH). Combinational from count only; no dependence on pop, so there is no full-queue bypass.
- Outputs id_valid/id_pc/id_inst/count are driven directly from flops. There is no combinational path from if_* or id_stall to id_*.
- Latency: push into an empty queue at edge N -> id_valid=1 with that PC/inst after edge N. Minimum IF->ID latency is 1 cycle, matching the old IF/ID register.
- Order is strict FIFO. The presented entry is always the oldest.
- Push only: entry written at tail, count+1. If queue was empty, the entry also becomes the presented entry.
- Pop only: next-oldest entry presented, count-1. If count becomes 0: id_valid=0, id_pc=0, id_inst=0.
- Push and pop together:
  - count unchanged.
  - If count was 1, the pushed entry becomes presented next cycle.
- id_stall=1 with id_valid=1: presented entry and outputs hold. Pushes continue until full.
- Full (count=DEPTH): if_ready=0; if_valid is ignored and IF must hold its offer.
- Empty with id_stall=1: no effect; outputs stay zero.
- Flush (highest priority after rst):
  - Next cycle count=0, id_valid=0, id_pc=0, id_inst=0.
  - A same-cycle push is dropped; a same-cycle pop is irrelevant.
- Pointers wrap modulo DEPTH. A full/empty ambiguity must not arise (count is authoritative).
- When id_valid=0, id_pc and id_inst are zero at all times (bubble).

Decomposition:
- Shared defs package (defs.v) provides:
  - RstEnable, Stop/NoStop, ZeroWord, InstAddrBus/InstBus widths.
  - A new `IfQueueDepth default for DEPTH.
- Natural sub-module: sync_fifo_mem — a DEPTH x (ADDR_W+INST_W) register array with write/read pointers, no reset on data.
- if_id_queue owns:
  - count;
  - the presented-entry output registers;
  - flush/reset control.

Test Plan:
- Reset, then if_valid=1 with pc=0x100, inst=0x24010001, id_stall=0 -> one cycle later id_valid=1, id_pc=0x100, id_inst=0x24010001, count=1. Next cycle id_valid=0, id_pc=0, id_inst=0.
- id_stall=1; push pc 0x0,0x4,0x8,0xC on 4 consecutive cycles -> count reaches 4, if_ready=0. A 5th offer at pc 0x10 is held, not accepted. Release stall -> ID sees 0x0,0x4,0x8,0xC,0x10 in order, one per cycle.
- count=1, simultaneous push (pc 0x20) and pop -> count stays 1, next cycle id_pc=0x20.
- count=3, flush=1 together with if_valid=1 at pc 0x40 -> next cycle count=0, id_valid=0, id_pc=0, id_inst=0. 0x40 never appears.
- rst=1 asserted while count=2 and id_stall=1 -> next cycle all outputs zero, if_ready=1. A subsequent push of pc 0x80 appears after 1 cycle.
- Pointer wrap: stream 10 entries with stall toggling every other cycle, DEPTH=4 -> order preserved, no loss or duplication, count never exceeds 4.
